// File: rtl/onehot_demux_if.sv
// Handshake bundle for onehot_demux: one upstream beat in, N one-hot lanes out.
// The master modport is the traffic side (source + sinks); the slave modport is the demux.
interface onehot_demux_if #(
  parameter int unsigned DW = 8,
  parameter int unsigned N  = 4
);
  logic          i_valid;
  logic          i_ready;
  logic [N-1:0]  i_sel;
  logic [DW-1:0] i_data;
  logic [N-1:0]  o_valid;
  logic [N-1:0]  o_ready;
  logic [DW-1:0] o_data;

  modport master (
    output i_valid, i_sel, i_data, o_ready,
    input  i_ready, o_valid, o_data
  );

  modport slave (
    input  i_valid, i_sel, i_data, o_ready,
    output i_ready, o_valid, o_data
  );
endinterface

// File: rtl/onehot_demux.sv
// Single-entry one-hot demultiplexer: registers one beat and presents it on the selected lane.
// Beats with a non-one-hot select are swallowed, flagged in err and counted in drop_cnt.
module onehot_demux #(
  parameter int unsigned DW = 8,
  parameter int unsigned N  = 4,
  parameter int unsigned CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  onehot_demux_if.slave bus,
  output logic          err,
  input  logic          err_clr,
  output logic [CW-1:0] drop_cnt
);

  typedef enum logic {StEmpty, StFull} state_t;

  state_t        r_state;
  logic [DW-1:0] r_data;
  logic [N-1:0]  r_sel;
  logic          r_err;
  logic [CW-1:0] r_drop_cnt;

  logic w_pop;
  logic w_accept;
  logic w_sel_ok;
  logic w_cnt_max;

  assign bus.o_valid = (r_state == StFull) ? r_sel : '0;
  assign bus.o_data  = r_data;

  assign w_pop     = |(bus.o_valid & bus.o_ready);
  // rst gates i_ready combinationally so nothing is accepted while reset is held.
  assign bus.i_ready = ~rst & ((r_state == StEmpty) | w_pop);
  assign w_accept  = bus.i_valid & bus.i_ready;
  assign w_sel_ok  = $onehot(bus.i_sel);
  assign w_cnt_max = (r_drop_cnt == {CW{1'b1}});

  assign err      = r_err;
  assign drop_cnt = r_drop_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StEmpty;
      r_data  <= '0;
      r_sel   <= '0;
    end else if (w_accept && w_sel_ok) begin
      r_state <= StFull;
      r_data  <= bus.i_data;
      r_sel   <= bus.i_sel;
    end else if (w_pop) begin
      r_state <= StEmpty;
    end
  end

  // err_clr wins over a same-cycle drop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err      <= 1'b0;
      r_drop_cnt <= '0;
    end else if (err_clr) begin
      r_err      <= 1'b0;
      r_drop_cnt <= '0;
    end else if (w_accept && !w_sel_ok) begin
      r_err <= 1'b1;
      if (!w_cnt_max) begin
        r_drop_cnt <= r_drop_cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_onehot_demux.sv
// Directed bench for onehot_demux: a queue-based scoreboard checked every cycle,
// plus hand-computed literal expectations for each scenario.
module tb_onehot_demux;
  localparam int unsigned DW = 8;
  localparam int unsigned N  = 4;

  logic clk;
  logic rst;
  logic err, err_clr;
  logic [7:0] drop_cnt;
  logic err2, err_clr2;
  logic [1:0] drop_cnt2;

  int passed = 0;
  int total  = 0;

  onehot_demux_if #(.DW(DW), .N(N)) u_if  ();
  onehot_demux_if #(.DW(DW), .N(N)) u_if2 ();

  onehot_demux #(.DW(DW), .N(N), .CW(8)) u_dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (u_if.slave),
    .err      (err),
    .err_clr  (err_clr),
    .drop_cnt (drop_cnt)
  );

  onehot_demux #(.DW(DW), .N(N), .CW(2)) u_dut2 (
    .clk      (clk),
    .rst      (rst),
    .bus      (u_if2.slave),
    .err      (err2),
    .err_clr  (err_clr2),
    .drop_cnt (drop_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Scoreboard: beats waiting to be presented, plus sticky error and drop count.
  typedef struct packed {
    logic [N-1:0]  lane;
    logic [DW-1:0] data;
  } beat_t;

  beat_t m_q[$];
  bit    m_err;
  int    m_drops;

  function automatic logic [N-1:0] m_ovalid();
    return (m_q.size() != 0) ? m_q[0].lane : '0;
  endfunction

  function automatic bit m_pop();
    return (m_q.size() != 0) && ((m_q[0].lane & u_if.o_ready) != '0);
  endfunction

  function automatic bit m_iready();
    return !rst && ((m_q.size() == 0) || m_pop());
  endfunction

  initial begin
    m_err   = 0;
    m_drops = 0;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_q.delete();
        m_err   = 0;
        m_drops = 0;
      end else begin
        bit acc;
        bit pop;
        acc = u_if.i_valid && m_iready();
        pop = m_pop();
        if (pop) void'(m_q.pop_front());
        if (acc && $countones(u_if.i_sel) == 1) m_q.push_back({u_if.i_sel, u_if.i_data});
        else if (acc) begin
          m_err   = 1;
          m_drops = (m_drops < 255) ? m_drops + 1 : 255;
        end
        if (err_clr) begin
          m_err   = 0;
          m_drops = 0;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("model o_valid", 32'(u_if.o_valid), 32'(m_ovalid()));
        chk("model i_ready", 32'(u_if.i_ready), 32'(m_iready()));
        if (m_q.size() != 0) chk("model o_data", 32'(u_if.o_data), 32'(m_q[0].data));
        chk("model err", 32'(err), 32'(m_err));
        chk("model drop_cnt", 32'(drop_cnt), 32'(m_drops));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [N-1:0] s, input logic [DW-1:0] d);
    u_if.i_valid = v;
    u_if.i_sel   = s;
    u_if.i_data  = d;
  endtask

  initial begin
    rst            = 1'b1;
    err_clr        = 1'b0;
    err_clr2       = 1'b0;
    drive(1'b0, '0, '0);
    u_if.o_ready   = '0;
    u_if2.i_valid  = 1'b0;
    u_if2.i_sel    = '0;
    u_if2.i_data   = '0;
    u_if2.o_ready  = '0;

    // Reset state
    #2;
    chk("rst i_ready", 32'(u_if.i_ready), 32'h0);
    chk("rst o_valid", 32'(u_if.o_valid), 32'h0);
    chk("rst err", 32'(err), 32'h0);
    chk("rst drop_cnt", 32'(drop_cnt), 32'h0);
    step();
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("post-rst i_ready", 32'(u_if.i_ready), 32'h1);
    step();

    // Single beat to lane 2
    drive(1'b1, 4'b0100, 8'hA5);
    step();
    drive(1'b0, '0, '0);
    @(negedge clk);
    chk("single o_valid", 32'(u_if.o_valid), 32'h4);
    chk("single o_data", 32'(u_if.o_data), 32'hA5);
    chk("single i_ready full", 32'(u_if.i_ready), 32'h0);
    u_if.o_ready = 4'b0100;
    #1;
    chk("single i_ready pop", 32'(u_if.i_ready), 32'h1);
    step();
    u_if.o_ready = '0;
    @(negedge clk);
    chk("single empty", 32'(u_if.o_valid), 32'h0);
    step();

    // Back-to-back stream, one beat per cycle
    u_if.o_ready = 4'hF;
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 4'(1 << (k % 4)), 8'(k + 1));
      @(negedge clk);
      chk("stream i_ready", 32'(u_if.i_ready), 32'h1);
      if (k > 0) begin
        chk("stream o_valid", 32'(u_if.o_valid), 32'(1 << ((k - 1) % 4)));
        chk("stream o_data", 32'(u_if.o_data), 32'(k));
      end
      step();
    end
    drive(1'b0, '0, '0);
    @(negedge clk);
    chk("stream last o_valid", 32'(u_if.o_valid), 32'h8);
    chk("stream last o_data", 32'(u_if.o_data), 32'h08);
    step();
    u_if.o_ready = '0;

    // Backpressure on lane 1 while other lanes are ready
    u_if.o_ready = 4'b1101;
    drive(1'b1, 4'b0010, 8'h3C);
    step();
    drive(1'b1, 4'b0001, 8'h5A);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("stall i_ready", 32'(u_if.i_ready), 32'h0);
      chk("stall o_valid", 32'(u_if.o_valid), 32'h2);
      chk("stall o_data", 32'(u_if.o_data), 32'h3C);
      step();
    end
    u_if.o_ready = 4'hF;
    @(negedge clk);
    chk("stall release i_ready", 32'(u_if.i_ready), 32'h1);
    step();
    drive(1'b0, '0, '0);
    @(negedge clk);
    chk("stall next o_valid", 32'(u_if.o_valid), 32'h1);
    chk("stall next o_data", 32'(u_if.o_data), 32'h5A);
    step();
    @(negedge clk);
    chk("stall drained", 32'(u_if.o_valid), 32'h0);
    u_if.o_ready = '0;
    step();

    // Invalid selects are dropped and counted
    drive(1'b1, 4'b0000, 8'h11);
    step();
    drive(1'b1, 4'b0110, 8'h22);
    step();
    drive(1'b0, '0, '0);
    @(negedge clk);
    chk("drop o_valid", 32'(u_if.o_valid), 32'h0);
    chk("drop err", 32'(err), 32'h1);
    chk("drop cnt", 32'(drop_cnt), 32'h2);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    @(negedge clk);
    chk("clr err", 32'(err), 32'h0);
    chk("clr cnt", 32'(drop_cnt), 32'h0);
    // err_clr beats a same-cycle drop
    drive(1'b1, 4'b1111, 8'h33);
    err_clr = 1'b1;
    step();
    drive(1'b0, '0, '0);
    err_clr = 1'b0;
    @(negedge clk);
    chk("clr prio err", 32'(err), 32'h0);
    chk("clr prio cnt", 32'(drop_cnt), 32'h0);
    step();

    // Saturation with CW=2
    u_if2.i_valid = 1'b1;
    u_if2.i_sel   = 4'b0011;
    for (int k = 0; k < 5; k++) step();
    u_if2.i_valid = 1'b0;
    @(negedge clk);
    chk("sat cnt", 32'(drop_cnt2), 32'h3);
    chk("sat err", 32'(err2), 32'h1);
    chk("sat o_valid", 32'(u_if2.o_valid), 32'h0);
    step();

    // Asynchronous reset while holding a beat
    drive(1'b1, 4'b1000, 8'hC3);
    step();
    drive(1'b0, '0, '0);
    @(negedge clk);
    chk("pre-rst o_valid", 32'(u_if.o_valid), 32'h8);
    #2;
    rst = 1'b1;
    #1;
    chk("async rst o_valid", 32'(u_if.o_valid), 32'h0);
    chk("async rst i_ready", 32'(u_if.i_ready), 32'h0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("after rst o_valid", 32'(u_if.o_valid), 32'h0);
    chk("after rst i_ready", 32'(u_if.i_ready), 32'h1);
    step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/onehot_demux.md
ONEHOT_DEMUX -- requirements
Module: onehot_demux

Interface
REQ-001: Parameter DW, default 8, SHALL be the payload data width in bits (DW >= 1).
REQ-002: Parameter N, default 4, SHALL be the number of output lanes (N >= 2).
REQ-003: Parameter CW, default 8, SHALL be the drop-counter width in bits (CW >= 1).
REQ-004: clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005: rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-006: i_valid  input  1  SHALL mark that the upstream beat is valid.
REQ-007: i_ready  output  1  SHALL mark that the block accepts the upstream beat this cycle.
REQ-008: i_sel  input  N  SHALL be the one-hot destination lane of the upstream beat.
REQ-009: i_data  input  DW  SHALL be the upstream payload.
REQ-010: o_valid  output  N  SHALL be the per-lane valid; at most one bit set.
REQ-011: o_ready  input  N  SHALL be the per-lane downstream ready.
REQ-012: o_data  output  DW  SHALL be the payload, shared by all lanes.
REQ-013: err  output  1  SHALL be a sticky flag: an invalid i_sel was accepted.
REQ-014: err_clr  input  1  SHALL synchronously clear err and drop_cnt.
REQ-015: drop_cnt  output  CW  SHALL count beats dropped for invalid i_sel.

Function
REQ-016: Block SHALL hold a single-entry output register (data_q, sel_q) plus state EMPTY/FULL.
REQ-017: Input handshake SHALL be i_valid & i_ready; lane-j handshake SHALL be o_valid[j] & o_ready[j].
REQ-018: o_valid[j] SHALL equal (state == FULL) & sel_q[j]; o_data SHALL equal data_q, independent of o_ready.
REQ-019: pop SHALL be the OR of all lane handshakes.
REQ-020: i_ready SHALL equal (state == EMPTY) | pop; i_ready does not depend on i_valid or i_sel.
REQ-021: o_ready to i_ready SHALL be the only combinational input-to-output path.
REQ-022: i_sel is valid when exactly one bit is set; zero or multi-hot is invalid.
REQ-023: Accepted beat with valid i_sel SHALL load data_q/sel_q and set state FULL next cycle, i.e. one cycle latency to o_valid.
REQ-024: Accepted beat with invalid i_sel SHALL be consumed and never presented: registers unchanged, err set next cycle, drop_cnt incremented.
REQ-025: Transitions: EMPTY -> FULL on valid-sel accept; FULL -> EMPTY on pop without valid-sel accept; FULL -> FULL on pop with valid-sel accept (back-to-back, 1 beat/cycle); otherwise hold.
REQ-026: While FULL and no pop, data_q and sel_q SHALL be held stable (no beat overwrite or loss).
REQ-027: FULL with pop plus invalid-sel accept SHALL go EMPTY and count the drop.
REQ-028: drop_cnt SHALL saturate at 2^CW-1 and not wrap.
REQ-029: err_clr SHALL take priority over a same-cycle drop: err=0, drop_cnt=0 next cycle.
REQ-030: o_ready on lanes where o_valid is low SHALL be ignored.

Reset
REQ-031: On rst assertion, immediately and regardless of clk: state=EMPTY, o_valid=0, data_q=0, sel_q=0, err=0, drop_cnt=0.
REQ-032: While rst is high, i_ready SHALL be 0; it returns to 1 in the first cycle after release.
REQ-033: rst asserted while FULL SHALL discard the held beat with no handshake on any lane.

Verification
REQ-034: After reset, i_valid=1, i_sel=4'b0100, i_data=8'hA5 for one cycle -> next cycle o_valid=4'b0100, o_data=8'hA5; o_ready[2]=1 -> EMPTY following cycle.
REQ-035: Stream 8'h01..8'h08 with sel rotating 0001,0010,0100,1000, all o_ready=1 -> 8 beats in order on matching lanes, one per cycle, i_ready constantly 1.
REQ-036: FULL with o_valid=4'b0010 and o_ready=4'b1101 for 5 cycles -> i_ready=0, o_data stable, no loss; raise o_ready[1] -> pop and accept same cycle.
REQ-037: Accept i_sel=4'b0000 then 4'b0110 -> no o_valid, err=1, drop_cnt=2; err_clr pulse -> err=0, drop_cnt=0.
REQ-038: CW=2, 5 invalid beats -> drop_cnt saturates at 3.
REQ-039: Assert rst mid-cycle while FULL -> o_valid=0 and i_ready=0 immediately, without a clock edge.
